// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential multiplier and its ALU.
//   - State encoding for the multiply sequencer FSM.
//   - ALU operation codes (SUB and SLT are reserved for a later divider).
package mul_seq_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_e;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu.sv
// Shared combinational ALU datapath (no carry-out).
//   a, b     : WIDTH-bit operands
//   alucont  : operation select (see mul_seq_pkg ALU_* codes)
//   result   : WIDTH-bit result; undefined opcodes return 0
module alu
  import mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alucont,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] diff;

  assign diff = a - b;

  // Operation select; SLT reports the sign of a-b in bit 0.
  always_comb begin
    result = '0;
    case (alucont)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = diff;
      ALU_SLT: result = WIDTH'(diff[WIDTH-1]);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned shift-add multiplier driving the shared ALU in ADD mode.
//   clk    : rising-edge clock
//   reset  : synchronous active-low reset
//   start  : request pulse, accepted only in IDLE
//   a, b   : multiplicand / multiplier, sampled on the accepting edge
//   busy   : high while not IDLE (RUN and DONE)
//   done   : one-cycle pulse, hi/lo hold the product
//   hi, lo : upper / lower halves of the 2*WIDTH-bit product
// Optional macro MULSEQ_ZERO_SKIP_EN: a zero operand bypasses RUN and goes
// straight to DONE with a zero product.
module alu_mul_seq
  import mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum;
  logic             carry;

  // Partial-product accumulate: hi + mcand.
  alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a      (hi_q),
    .b      (mcand_q),
    .alucont(ALU_ADD),
    .result (sum)
  );

  // Unsigned wrap of the sum means the add carried out.
  assign carry = (sum < hi_q);

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    count_d = count_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef MULSEQ_ZERO_SKIP_EN
          if ((a == '0) || (b == '0)) begin
            mcand_d = a;
            hi_d    = '0;
            lo_d    = '0;
            count_d = '0;
            state_d = ST_DONE;
          end else begin
            mcand_d = a;
            lo_d    = b;
            hi_d    = '0;
            count_d = CNT_W'(WIDTH);
            state_d = ST_RUN;
          end
`else
          mcand_d = a;
          lo_d    = b;
          hi_d    = '0;
          count_d = CNT_W'(WIDTH);
          state_d = ST_RUN;
`endif
        end
      end

      ST_RUN: begin
        // Shift the {carry, hi, lo} chain right by one, adding mcand first
        // when the current multiplier bit is set.
        if (lo_q[0]) begin
          hi_d = {carry, sum[WIDTH-1:1]};
          lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end else begin
          hi_d = {1'b0, hi_q[WIDTH-1:1]};
          lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
        end
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Moore outputs registered alongside the state they describe.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: directed cases then random traffic.
module tb_alu_mul_seq;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  alu_mul_seq #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int prod;
    int done_cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks   = 0;
  int   errors   = 0;
  int   free_cyc = 0;
  int   busy_lo  = 1;
  int   busy_hi  = 0;
  bit   mon_en   = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Cycles from the start cycle to the done cycle.
  function automatic int lat_of(input int av, input int bv);
`ifdef MULSEQ_ZERO_SKIP_EN
    if (av == 0 || bv == 0) return 1;
`endif
    return WIDTH + 1;
  endfunction

  // One cycle of stimulus; the model decides acceptance from its own timeline.
  task automatic drive(input bit s, input int av, input int bv);
    int l;
    @(negedge clk);
    start = s;
    a     = WIDTH'(av);
    b     = WIDTH'(bv);
    if (s && cyc >= free_cyc) begin
      l = lat_of(av, bv);
      q.push_back('{prod: av * bv, done_cyc: cyc + l});
      busy_lo  = cyc + 1;
      busy_hi  = cyc + l;
      free_cyc = cyc + l + 1;
    end
  endtask

  task automatic wait_idle();
    while (cyc + 1 < free_cyc) drive(1'b0, int'($urandom_range(0, 255)), 0);
  endtask

  // Reset in the upcoming cycle; busy still reads high during that cycle.
  task automatic mid_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    q.delete();
    if (busy_hi > cyc) busy_hi = cyc;
    free_cyc = cyc + 1000000;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    reset    = 1'b1;
    free_cyc = cyc;
  endtask

  function automatic int rnd_op();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return 255;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  // Monitor: busy window each cycle, and pop/compare on every done pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done actual=1 expected=0 cycle=%0d", cyc);
        end else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("product", {hi, lo}, e.prod);
        end
      end else if (q.size() > 0 && cyc > q[0].done_cyc) begin
        e = q.pop_front();
        chk("done_missing", cyc - 1, e.done_cyc + 1);
      end
    end
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_hi", hi, 0);
    chk("init_lo", lo, 0);
    reset    = 1'b1;
    free_cyc = cyc;
    mon_en   = 1'b1;

    // 13 * 11
    drive(1'b1, 13, 11);
    wait_idle();
    // 255 * 255 exercises the carry bit
    drive(1'b1, 255, 255);
    wait_idle();
    // start while busy is ignored
    drive(1'b1, 13, 11);
    repeat (3) drive(1'b0, 0, 0);
    drive(1'b1, 1, 1);
    wait_idle();
    // reset in cycle 5 of RUN discards the result, then a fresh op completes
    drive(1'b1, 13, 11);
    repeat (4) drive(1'b0, 0, 0);
    mid_reset();
    drive(1'b1, 13, 11);
    wait_idle();
    // zero operand
    drive(1'b1, 0, 200);
    wait_idle();
    // back-to-back: second start in the cycle after done
    drive(1'b1, 13, 11);
    wait_idle();
    drive(1'b1, 3, 7);
    wait_idle();

    // random traffic, including starts while busy
    repeat (400) drive($urandom_range(0, 2) == 0, rnd_op(), rnd_op());
    start = 1'b0;
    wait_idle();
    repeat (3) drive(1'b0, 0, 0);

    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
